// File: rtl/byte_data_memory.sv
// Byte-addressable data memory for the load/store path: byte/half/word access,
// load extension, misalignment rejection and a fixed wait-state handshake.
module byte_data_memory #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic                     wr_en_i,
    input  logic [1:0]               size_i,
    input  logic                     unsigned_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [31:0]              data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [31:0]              data_o,
    output logic                     misaligned_o
);

    localparam int DEPTH = 2 ** (ADDRESS_WIDTH - 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]               state;
    logic [3:0]               cnt;
    logic                     wr_q;
    logic [1:0]               size_q;
    logic                     uns_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [31:0]              wdata_q;
    logic                     mis_q;

    logic                     accept;
    logic                     mis_in;
    logic [3:0]               be;
    logic [31:0]              wdata_al;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-3:0] idx;
    logic [31:0]              rd_word;
    logic [7:0]               rd_byte;
    logic [15:0]              rd_half;
    logic [31:0]              load_val;

    logic [31:0] mem [DEPTH];

    assign accept = req_i && (state == ST_IDLE);
    assign idx    = addr_q[ADDRESS_WIDTH-1:2];

    always_comb begin
        mis_in = 1'b0;
        case (size_i)
            2'b00:   mis_in = 1'b0;
            2'b01:   mis_in = addr_i[0];
            2'b10:   mis_in = (addr_i[1:0] != 2'b00);
            default: mis_in = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            data_o  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= wr_en_i;
                        size_q  <= size_i;
                        uns_q   <= unsigned_i;
                        addr_q  <= addr_i;
                        wdata_q <= data_i;
                        mis_q   <= mis_in;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_ACCESS;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_ACCESS: begin
                    // Load result is captured here and held until the next load
                    if (!wr_q) data_o <= mis_q ? 32'd0 : load_val;
                    state <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target
    always_comb begin
        be       = 4'b0000;
        wdata_al = 32'd0;
        case (size_q)
            2'b00: begin
                be[addr_q[1:0]] = 1'b1;
                wdata_al        = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata_q[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wdata_al = wdata_q;
            end
        endcase
    end

    assign mem_we = (state == ST_ACCESS) && wr_q && !mis_q;

    // Array is not reset; a reset coincident with the access edge blocks the write
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[8*addr_q[1:0] +: 8];
    assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (size_q)
            2'b00:   load_val = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            2'b01:   load_val = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    assign ready_o      = (state == ST_IDLE);
    assign valid_o      = (state == ST_RESP);
    assign misaligned_o = valid_o && mis_q;

endmodule
